// File: rtl/video_pkg.sv
// Shared video constants, colour width and blitter FSM encoding used by the
// sprite read/plot path.
package video_pkg;

  localparam int VID_SCREEN_X_WIDTH = 8;
  localparam int VID_SCREEN_Y_WIDTH = 7;
  localparam int VID_SCREEN_W       = 160;
  localparam int VID_SCREEN_H       = 120;
  localparam int COLOR_W            = 3;

  localparam logic [COLOR_W-1:0] DEF_TRANSPARENT_COLOR = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } blit_state_e;

endpackage

// File: rtl/sprite_addr_counter.sv
// Row-major sprite address counter: x runs fastest, wraps to (0,0) after the
// last address. clr has priority over en.
module sprite_addr_counter #(
  parameter int SPRITE_W = 10,
  parameter int SPRITE_H = 6,
  parameter int WIDTH_X  = 4,
  parameter int WIDTH_Y  = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               clr,
  input  logic               en,
  output logic [WIDTH_X-1:0] x,
  output logic [WIDTH_Y-1:0] y,
  output logic               last
);

  localparam logic [WIDTH_X-1:0] X_MAX = WIDTH_X'(SPRITE_W - 1);
  localparam logic [WIDTH_Y-1:0] Y_MAX = WIDTH_Y'(SPRITE_H - 1);

  logic [WIDTH_X-1:0] x_q, x_d;
  logic [WIDTH_Y-1:0] y_q, y_d;
  logic               x_last;
  logic               y_last;

  assign x_last = (x_q == X_MAX);
  assign y_last = (y_q == Y_MAX);

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (en) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : y_q + WIDTH_Y'(1);
      end else begin
        x_d = x_q + WIDTH_X'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = x_last && y_last;

endmodule

// File: rtl/sprite_blitter.sv
// Copies a sprite from sprite RAM to the VGA plot port at a latched screen
// origin, clipping off-screen and transparent pixels.
module sprite_blitter
  import video_pkg::*;
#(
  parameter int                 WIDTH_X           = 4,
  parameter int                 WIDTH_Y           = 3,
  parameter int                 SPRITE_W          = 10,
  parameter int                 SPRITE_H          = 6,
  parameter int                 SCREEN_X_WIDTH    = VID_SCREEN_X_WIDTH,
  parameter int                 SCREEN_Y_WIDTH    = VID_SCREEN_Y_WIDTH,
  parameter int                 SCREEN_W          = VID_SCREEN_W,
  parameter int                 SCREEN_H          = VID_SCREEN_H,
  parameter bit                 TRANSPARENT_EN    = 1'b1,
  parameter logic [COLOR_W-1:0] TRANSPARENT_COLOR = DEF_TRANSPARENT_COLOR
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  input  logic [SCREEN_X_WIDTH-1:0] origin_x,
  input  logic [SCREEN_Y_WIDTH-1:0] origin_y,
  output logic                      busy,
  output logic                      done,
  output logic [WIDTH_X-1:0]        sprite_x,
  output logic [WIDTH_Y-1:0]        sprite_y,
  input  logic [COLOR_W-1:0]        sprite_color,
  output logic [SCREEN_X_WIDTH-1:0] vga_x,
  output logic [SCREEN_Y_WIDTH-1:0] vga_y,
  output logic [COLOR_W-1:0]        vga_colour,
  output logic                      vga_plot,
  output logic [1:0]                state_dbg
);

  // Handshake: start is a level sampled only in IDLE; done is a single-cycle
  // pulse in DONE, and busy covers SCAN and DRAIN. vga_plot is a write strobe
  // with no back-pressure: every asserted cycle is one pixel.

  localparam logic [SCREEN_X_WIDTH:0] X_LIM = (SCREEN_X_WIDTH + 1)'(SCREEN_W);
  localparam logic [SCREEN_Y_WIDTH:0] Y_LIM = (SCREEN_Y_WIDTH + 1)'(SCREEN_H);

  blit_state_e state_q, state_d;
  logic        drain_q, drain_d;

  logic [SCREEN_X_WIDTH-1:0] org_x_q, org_x_d;
  logic [SCREEN_Y_WIDTH-1:0] org_y_q, org_y_d;

  logic cnt_clr;
  logic cnt_en;
  logic cnt_last;

  logic [WIDTH_X-1:0] s1_x_q, s1_x_d;
  logic [WIDTH_Y-1:0] s1_y_q, s1_y_d;
  logic               s1_vld_q, s1_vld_d;

  logic [SCREEN_X_WIDTH:0] sum_x;
  logic [SCREEN_Y_WIDTH:0] sum_y;
  logic                    opaque;

  logic [SCREEN_X_WIDTH-1:0] vga_x_q, vga_x_d;
  logic [SCREEN_Y_WIDTH-1:0] vga_y_q, vga_y_d;
  logic [COLOR_W-1:0]        vga_c_q, vga_c_d;
  logic                      vga_plot_q, vga_plot_d;

  sprite_addr_counter #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .WIDTH_X  (WIDTH_X),
    .WIDTH_Y  (WIDTH_Y)
  ) u_addr (
    .clk    (clk),
    .resetn (resetn),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .x      (sprite_x),
    .y      (sprite_y),
    .last   (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    org_x_d = org_x_q;
    org_y_d = org_y_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          org_x_d = origin_x;
          org_y_d = origin_y;
          cnt_clr = 1'b1;
        end
      end
      ST_SCAN: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d = ST_DRAIN;
          drain_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        // Two cycles: enough for the last address to leave both stages.
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = ST_DONE;
          drain_d = 1'b0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stage 1 delays the address so it lines up with the RAM read data.
  always_comb begin
    s1_vld_d = (state_q == ST_SCAN);
    s1_x_d   = sprite_x;
    s1_y_d   = sprite_y;
  end

  // Stage 2: translate one bit wider than the screen so no sum wraps back
  // on-screen, then clip and key out transparent pixels.
  always_comb begin
    sum_x      = {1'b0, org_x_q} + (SCREEN_X_WIDTH + 1)'(s1_x_q);
    sum_y      = {1'b0, org_y_q} + (SCREEN_Y_WIDTH + 1)'(s1_y_q);
    opaque     = !(TRANSPARENT_EN && (sprite_color == TRANSPARENT_COLOR));
    vga_plot_d = s1_vld_q && (sum_x < X_LIM) && (sum_y < Y_LIM) && opaque;
    vga_x_d    = vga_x_q;
    vga_y_d    = vga_y_q;
    vga_c_d    = vga_c_q;
    if (s1_vld_q) begin
      vga_x_d = sum_x[SCREEN_X_WIDTH-1:0];
      vga_y_d = sum_y[SCREEN_Y_WIDTH-1:0];
      vga_c_d = sprite_color;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      drain_q    <= 1'b0;
      org_x_q    <= '0;
      org_y_q    <= '0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_vld_q   <= 1'b0;
      vga_x_q    <= '0;
      vga_y_q    <= '0;
      vga_c_q    <= '0;
      vga_plot_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      org_x_q    <= org_x_d;
      org_y_q    <= org_y_d;
      s1_x_q     <= s1_x_d;
      s1_y_q     <= s1_y_d;
      s1_vld_q   <= s1_vld_d;
      vga_x_q    <= vga_x_d;
      vga_y_q    <= vga_y_d;
      vga_c_q    <= vga_c_d;
      vga_plot_q <= vga_plot_d;
    end
  end

  assign busy       = (state_q == ST_SCAN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_c_q;
  assign vga_plot   = vga_plot_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter: two instances (keying on and off) share
// stimulus, each with its own synchronous sprite RAM model.
module tb_sprite_blitter;
  import video_pkg::*;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [7:0] origin_x;
  logic [6:0] origin_y;

  logic       busy_a, done_a, plot_a, busy_b, done_b, plot_b;
  logic [3:0] sx_a, sx_b;
  logic [2:0] sy_a, sy_b;
  logic [2:0] col_a, col_b, vc_a, vc_b;
  logic [7:0] vx_a, vx_b;
  logic [6:0] vy_a, vy_b;
  logic [1:0] st_a, st_b;

  logic [2:0] mem [60];

  int vec_cnt = 0;
  int err_cnt = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  sprite_blitter #(.TRANSPARENT_EN(1'b1)) u_dut_a (
    .clk (clk), .resetn (resetn), .start (start),
    .origin_x (origin_x), .origin_y (origin_y),
    .busy (busy_a), .done (done_a),
    .sprite_x (sx_a), .sprite_y (sy_a), .sprite_color (col_a),
    .vga_x (vx_a), .vga_y (vy_a), .vga_colour (vc_a), .vga_plot (plot_a),
    .state_dbg (st_a)
  );

  sprite_blitter #(.TRANSPARENT_EN(1'b0)) u_dut_b (
    .clk (clk), .resetn (resetn), .start (start),
    .origin_x (origin_x), .origin_y (origin_y),
    .busy (busy_b), .done (done_b),
    .sprite_x (sx_b), .sprite_y (sy_b), .sprite_color (col_b),
    .vga_x (vx_b), .vga_y (vy_b), .vga_colour (vc_b), .vga_plot (plot_b),
    .state_dbg (st_b)
  );

  function automatic logic [2:0] ram_rd(input logic [3:0] x, input logic [2:0] y);
    int i;
    i = int'(y) * 10 + int'(x);
    if (i > 59) i = 0;
    return mem[i];
  endfunction

  always @(posedge clk) begin
    col_a <= ram_rd(sx_a, sy_a);
    col_b <= ram_rd(sx_b, sy_b);
  end

  // ---------------- scoreboard check ----------------
  task automatic check_val(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic fill_opaque();
    for (int i = 0; i < 60; i++) mem[i] = 3'b101;
  endtask

  task automatic fill_striped();
    for (int i = 0; i < 60; i++)
      mem[i] = ((i % 10) % 2 == 0) ? 3'b000 : 3'(((i % 10) + (i / 10)) % 7 + 1);
  endtask

  // ---------------- driver: one full blit ----------------
  // Entered at #1 after an edge (call it cycle 0); returns in cycle 64.
  task automatic blit(input string name, input int ox, input int oy,
                      input bit poke, input int exp_a, input int exp_b);
    int na, nb, nd, idx, sx, sy, col;
    bit inb, ea, eb;
    na = 0; nb = 0; nd = 0;
    check_val({name, ":c0_busy"}, int'(busy_a), 0);
    check_val({name, ":c0_state"}, int'(st_a), int'(ST_IDLE));
    origin_x = 8'(ox);
    origin_y = 7'(oy);
    start    = 1'b1;
    for (int cyc = 1; cyc <= 63; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check_val({name, ":busy"}, int'(busy_a), (cyc <= 62) ? 1 : 0);
      check_val({name, ":done"}, int'(done_a), (cyc == 63) ? 1 : 0);
      check_val({name, ":done_b"}, int'(done_b), (cyc == 63) ? 1 : 0);
      if (cyc <= 60) begin
        check_val({name, ":addr_x"}, int'(sx_a), (cyc - 1) % 10);
        check_val({name, ":addr_y"}, int'(sy_a), (cyc - 1) / 10);
      end
      if (cyc == 61) check_val({name, ":drain"}, int'(st_a), int'(ST_DRAIN));
      ea = 1'b0; eb = 1'b0; sx = 0; sy = 0; col = 0;
      if (cyc >= 3 && cyc <= 62) begin
        idx = cyc - 3;
        sx  = ox + idx % 10;
        sy  = oy + idx / 10;
        col = int'(mem[idx]);
        inb = (sx < 160) && (sy < 120);
        ea  = inb && (col != 0);
        eb  = inb;
      end
      check_val({name, ":plot_a"}, int'(plot_a), int'(ea));
      check_val({name, ":plot_b"}, int'(plot_b), int'(eb));
      if (plot_a && ea) begin
        check_val({name, ":vx_a"}, int'(vx_a), sx);
        check_val({name, ":vy_a"}, int'(vy_a), sy);
        check_val({name, ":vc_a"}, int'(vc_a), col);
      end
      if (plot_b && eb) begin
        check_val({name, ":vx_b"}, int'(vx_b), sx);
        check_val({name, ":vy_b"}, int'(vy_b), sy);
        check_val({name, ":vc_b"}, int'(vc_b), col);
      end
      if (plot_a) na++;
      if (plot_b) nb++;
      if (done_a) nd++;
      if (poke && (cyc == 20 || cyc == 63)) begin
        start    = 1'b1;
        origin_x = 8'd50;
        origin_y = 7'd40;
      end
    end
    @(posedge clk); #1;
    check_val({name, ":c64_state"}, int'(st_a), int'(ST_IDLE));
    check_val({name, ":c64_done"}, int'(done_a), 0);
    check_val({name, ":plots_a"}, na, exp_a);
    check_val({name, ":plots_b"}, nb, exp_b);
    check_val({name, ":dones"}, nd, 1);
    start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    resetn   = 1'b0;
    start    = 1'b0;
    origin_x = '0;
    origin_y = '0;
    fill_opaque();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", int'(busy_a), 0);
    check_val("rst_done", int'(done_a), 0);
    check_val("rst_plot", int'(plot_a), 0);
    check_val("rst_sx", int'(sx_a), 0);
    check_val("rst_vx", int'(vx_a), 0);
    check_val("rst_vc", int'(vc_a), 0);
    check_val("rst_state", int'(st_a), int'(ST_IDLE));
    resetn = 1'b1;
    @(posedge clk); #1;

    // Opaque sprite at the screen corner.
    blit("opaque", 0, 0, 1'b0, 60, 60);

    // Clipping at the bottom-right edge: 5 columns x 3 rows survive.
    blit("clip", 155, 117, 1'b0, 15, 15);

    // Transparent even columns: keyed instance plots only odd x.
    fill_striped();
    blit("transp", 20, 30, 1'b0, 30, 60);

    // Stray starts in SCAN and DONE are ignored; back-to-back start in 64.
    fill_opaque();
    blit("ignore", 7, 9, 1'b1, 60, 60);
    blit("b2b", 150, 0, 1'b0, 60, 60);

    // Asynchronous reset in cycle 20 of a blit.
    origin_x = 8'd0;
    origin_y = 7'd0;
    start    = 1'b1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    check_val("pre_rst_plot", int'(plot_a), 1);
    check_val("pre_rst_busy", int'(busy_a), 1);
    #2 resetn = 1'b0;
    #1;
    check_val("arst_plot_a", int'(plot_a), 0);
    check_val("arst_plot_b", int'(plot_b), 0);
    check_val("arst_busy", int'(busy_a), 0);
    check_val("arst_done", int'(done_a), 0);
    check_val("arst_state", int'(st_a), int'(ST_IDLE));
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      @(posedge clk); #1;
      check_val("post_rst_plot", int'(plot_a), 0);
      check_val("post_rst_busy", int'(busy_a), 0);
    end
    blit("after_rst", 0, 0, 1'b0, 60, 60);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
Copies a sprite from sprite RAM onto the VGA framebuffer at a run-time screen origin.
- Scans sprite addresses (x, y) row-major and presents them to a sprite_ram_module.
- Aligns the returned colour with its coordinates and translates to screen space.
- Clips off-screen pixels, drops transparent pixels, and drives the VGA adapter plot port.
- Sits between the game FSM (start/done handshake) and the VGA adapter; it is the writer side of the sprite-read path.

Parameters:
WIDTH_X, 4, sprite x address width
WIDTH_Y, 3, sprite y address width
SPRITE_W, 10, sprite width in pixels (≤ 2^WIDTH_X)
SPRITE_H, 6, sprite height in pixels (≤ 2^WIDTH_Y)
SCREEN_X_WIDTH, 8, screen x coordinate width
SCREEN_Y_WIDTH, 7, screen y coordinate width
SCREEN_W, 160, screen width in pixels
SCREEN_H, 120, screen height in pixels
TRANSPARENT_EN, 1, 1 = suppress pixels equal to TRANSPARENT_COLOR
TRANSPARENT_COLOR, 3'b000, colour key

Ports:
clk  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  request a blit; sampled only in IDLE
origin_x  in  SCREEN_X_WIDTH  screen x of sprite pixel (0,0); latched on start
origin_y  in  SCREEN_Y_WIDTH  screen y of sprite pixel (0,0); latched on start
busy  out  1  high in SCAN and DRAIN
done  out  1  one-cycle pulse when blit completes
sprite_x  out  WIDTH_X  sprite RAM x address (registered)
sprite_y  out  WIDTH_Y  sprite RAM y address (registered)
sprite_color  in  3  RAM data; valid the cycle after the address is presented
vga_x  out  SCREEN_X_WIDTH  plot x (registered)
vga_y  out  SCREEN_Y_WIDTH  plot y (registered)
vga_colour  out  3  plot colour (registered)
vga_plot  out  1  write strobe to VGA adapter (registered)

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE.
  - busy, done, vga_plot, sprite_x, sprite_y, vga_x, vga_y, vga_colour, latched origin and pipeline valid bits = 0.
  - Reset mid-blit aborts immediately. No further plots occur.
- FSM states:
  - IDLE: start=1 → latch origin, go to SCAN, address counter = (0,0).
  - SCAN: one address per cycle, x fastest. x wraps SPRITE_W−1 → 0 with y+1. After address (SPRITE_W−1, SPRITE_H−1) → DRAIN.
  - DRAIN: 2 cycles, flushes the pipeline, then → DONE.
  - DONE: 1 cycle, done=1, busy=0, then → IDLE.
- start is ignored outside IDLE, including during the DONE cycle.
- Pipeline and latency:
  - Address presented in cycle k; sprite_color valid in cycle k+1; vga_* registered and valid in cycle k+2.
  - Stage 1 delays (x, y, valid) one cycle to meet sprite_color.
  - Exactly one vga_plot candidate per scanned address, in scan order.
- Translation: screen_x = origin_x + x, screen_y = origin_y + y. Both are computed one bit wider than screen width, with no wrap-around.
- Plot condition: valid AND screen_x < SCREEN_W AND screen_y < SCREEN_H AND NOT (TRANSPARENT_EN AND sprite_color == TRANSPARENT_COLOR).
- vga_x, vga_y and vga_colour load every pipeline-valid cycle, truncated to port width. When vga_plot=0 their values are don't-care.
- Total duration: start sampled at edge 1 → done high in cycle SPRITE_W*SPRITE_H + 3 → IDLE the following cycle.

Decomposition:
- Shared package video_pkg holds:
  - SCREEN_W, SCREEN_H and screen coordinate widths
  - COLOR_W = 3
  - FSM state encoding (IDLE, SCAN, DRAIN, DONE)
  - default TRANSPARENT_COLOR
- One sub-module, sprite_addr_counter: row-major x/y counter with clear, enable and a last-address flag, parameterised by SPRITE_W/SPRITE_H.

Test Plan:
1. Opaque 10x6 sprite (all colour 3'b101), origin (0,0), start high in cycle 0:
   - busy from cycle 1.
   - First vga_plot at (0,0) in cycle 3; last at (9,5) in cycle 62.
   - Exactly 60 plots; done=1 only in cycle 63.
2. Clipping, origin (155,117):
   - Exactly 15 plots: x 155..159, y 117..119.
   - No plot with vga_x ≥ 160 or vga_y ≥ 120.
   - done still in cycle 63.
3. Transparency, sprite with colour 3'b000 on every even x, TRANSPARENT_EN=1:
   - 30 plots, all odd-x pixels, colour as stored.
   - With TRANSPARENT_EN=0: 60 plots.
4. start pulsed during SCAN (cycle 20) and in the DONE cycle (63):
   - Both ignored; origin unchanged; single done.
   - start in cycle 64 begins a new blit, with first plot in cycle 67.
5. resetn low asynchronously in cycle 20 of a blit:
   - vga_plot, busy and done go to 0 before the next edge.
   - After release, no plots until a new start; the next blit behaves as in scenario 1.
